// File: rtl/multi_digit_bcd_counter.sv
// Parametrised N-digit BCD up/down counter.
// Loadable, enable-gated and cascadable through CI/CO, with an optional
// saturate mode at terminal count. Each loaded digit above 9 is clamped to 9
// and flagged. All outputs are registered.
module multi_digit_bcd_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                ENABLE,
  input  logic                CI,
  input  logic                LOAD,
  input  logic                UP,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                CO,
  output logic                ZERO,
  output logic                LOAD_ERR
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         co_q, co_d;
  logic         zero_q, zero_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] load_val_s;
  logic         load_bad_s;
  logic [W-1:0] up_val_s;
  logic [W-1:0] dn_val_s;
  logic         term_up_s;
  logic         term_dn_s;

  // Replaces a non-decimal digit with 9 so Q never holds an invalid digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] dig);
    return (dig > 4'd9) ? 4'd9 : dig;
  endfunction

  // Clamp each load digit to 9 and note whether any digit had to be clamped.
  always_comb begin
    load_val_s = '0;
    load_bad_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      load_val_s[4*k +: 4] = clamp_digit(D[4*k +: 4]);
      load_bad_s           = load_bad_s | (D[4*k +: 4] > 4'd9);
    end
  end

  // Per-digit compare chain: a digit steps only when every lower digit sits at its limit.
  always_comb begin
    logic [3:0] dig_s;
    logic       carry_s;
    logic       borrow_s;
    dig_s    = 4'd0;
    carry_s  = 1'b1;
    borrow_s = 1'b1;
    up_val_s = '0;
    dn_val_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig_s = q_q[4*k +: 4];
      if (carry_s) begin
        up_val_s[4*k +: 4] = (dig_s == 4'd9) ? 4'd0 : (dig_s + 4'd1);
      end else begin
        up_val_s[4*k +: 4] = dig_s;
      end
      if (borrow_s) begin
        dn_val_s[4*k +: 4] = (dig_s == 4'd0) ? 4'd9 : (dig_s - 4'd1);
      end else begin
        dn_val_s[4*k +: 4] = dig_s;
      end
      carry_s  = carry_s & (dig_s == 4'd9);
      borrow_s = borrow_s & (dig_s == 4'd0);
    end
    term_up_s = carry_s;
    term_dn_s = borrow_s;
  end

  // Next-state selection: load beats count, and nothing moves without ENABLE.
  always_comb begin
    q_d        = q_q;
    co_d       = 1'b0;
    load_err_d = 1'b0;
    if (!ENABLE) begin
      q_d = q_q;
    end else if (LOAD) begin
      q_d        = load_val_s;
      load_err_d = load_bad_s;
    end else if (!CI) begin
      q_d = q_q;
    end else if (UP) begin
      co_d = term_up_s;
      if (term_up_s && SATURATE) begin
        q_d = q_q;
      end else begin
        q_d = up_val_s;
      end
    end else begin
      co_d = term_dn_s;
      if (term_dn_s && SATURATE) begin
        q_d = q_q;
      end else begin
        q_d = dn_val_s;
      end
    end
    zero_d = (q_d == '0);
  end

  // State and flag registers; CLR clears everything asynchronously.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_q        <= '0;
      co_q       <= 1'b0;
      zero_q     <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      co_q       <= co_d;
      zero_q     <= zero_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign CO       = co_q;
  assign ZERO     = zero_q;
  assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Bench for multi_digit_bcd_counter: a wrapping and a saturating 4-digit
// counter on shared inputs, plus two cascaded 2-digit stages. An integer
// model of each counter is compared every cycle; directed literals pin it.
module tb_multi_digit_bcd_counter;

  typedef struct packed {
    int   val;
    logic co;
    logic lerr;
  } mres_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0, ci = 1'b0, ld = 1'b0, up = 1'b1;
  logic [15:0] d = 16'd0;
  logic [15:0] q0, q1;
  logic        co0, co1, z0, z1, le0, le1;

  logic        c_en = 1'b0, c_ci = 1'b0, c_ld = 1'b0, c_up = 1'b1;
  logic [7:0]  c_d = 8'd0;
  logic [7:0]  q_lo, q_hi;
  logic        co_lo, co_hi, z_lo, z_hi, le_lo, le_hi;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    chk_on = 1'b0;
  mres_t m [4];

  always #5 clk = ~clk;

  multi_digit_bcd_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .CLK(clk), .CLR(clr), .ENABLE(en), .CI(ci), .LOAD(ld), .UP(up), .D(d),
    .Q(q0), .CO(co0), .ZERO(z0), .LOAD_ERR(le0));

  multi_digit_bcd_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .CLK(clk), .CLR(clr), .ENABLE(en), .CI(ci), .LOAD(ld), .UP(up), .D(d),
    .Q(q1), .CO(co1), .ZERO(z1), .LOAD_ERR(le1));

  multi_digit_bcd_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_lo (
    .CLK(clk), .CLR(clr), .ENABLE(c_en), .CI(c_ci), .LOAD(c_ld), .UP(c_up), .D(c_d),
    .Q(q_lo), .CO(co_lo), .ZERO(z_lo), .LOAD_ERR(le_lo));

  multi_digit_bcd_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_hi (
    .CLK(clk), .CLR(clr), .ENABLE(c_en), .CI(co_lo), .LOAD(c_ld), .UP(c_up), .D(c_d),
    .Q(q_hi), .CO(co_hi), .ZERO(z_hi), .LOAD_ERR(le_hi));

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int digits);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Counter behaviour as plain decimal arithmetic on an integer value.
  function automatic mres_t mstep(input int digits, input bit sat, input mres_t cur,
                                  input logic e, input logic l, input logic c,
                                  input logic u, input logic [31:0] dv);
    mres_t r;
    int maxv, p;
    logic [3:0] nib;
    r.val  = cur.val;
    r.co   = 1'b0;
    r.lerr = 1'b0;
    maxv   = pow10(digits) - 1;
    if (e && l) begin
      r.val = 0;
      p = 1;
      for (int k = 0; k < digits; k++) begin
        nib = dv[4*k +: 4];
        if (nib > 4'd9) begin
          r.lerr = 1'b1;
          nib = 4'd9;
        end
        r.val = r.val + int'(nib) * p;
        p = p * 10;
      end
    end else if (e && c && u) begin
      if (cur.val == maxv) begin
        r.co  = 1'b1;
        r.val = sat ? maxv : 0;
      end else begin
        r.val = cur.val + 1;
      end
    end else if (e && c && !u) begin
      if (cur.val == 0) begin
        r.co  = 1'b1;
        r.val = sat ? 0 : maxv;
      end else begin
        r.val = cur.val - 1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced on the same edges as the DUTs.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 4; i++) m[i] <= '0;
    end else begin
      m[0] <= mstep(4, 1'b0, m[0], en, ld, ci, up, {16'd0, d});
      m[1] <= mstep(4, 1'b1, m[1], en, ld, ci, up, {16'd0, d});
      m[2] <= mstep(2, 1'b0, m[2], c_en, c_ld, c_ci, c_up, {24'd0, c_d});
      m[3] <= mstep(2, 1'b0, m[3], c_en, c_ld, m[2].co, c_up, {24'd0, c_d});
    end
  end

  // Every-cycle comparison of all four DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wrap_q",    32'(q0),    to_bcd(m[0].val, 4));
      chk("wrap_co",   32'(co0),   32'(m[0].co));
      chk("wrap_zero", 32'(z0),    32'(m[0].val == 0));
      chk("wrap_lerr", 32'(le0),   32'(m[0].lerr));
      chk("sat_q",     32'(q1),    to_bcd(m[1].val, 4));
      chk("sat_co",    32'(co1),   32'(m[1].co));
      chk("sat_zero",  32'(z1),    32'(m[1].val == 0));
      chk("sat_lerr",  32'(le1),   32'(m[1].lerr));
      chk("lo_q",      32'(q_lo),  to_bcd(m[2].val, 2));
      chk("lo_co",     32'(co_lo), 32'(m[2].co));
      chk("lo_zero",   32'(z_lo),  32'(m[2].val == 0));
      chk("hi_q",      32'(q_hi),  to_bcd(m[3].val, 2));
      chk("hi_co",     32'(co_hi), 32'(m[3].co));
      chk("hi_zero",   32'(z_hi),  32'(m[3].val == 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 clr = 1'b0;
    tick(2);
    chk_on = 1'b1;
    chk("rst_q", 32'(q0), 32'h0);
    chk("rst_zero", 32'(z0), 32'h1);
    chk("rst_co", 32'(co0), 32'h0);
    chk("rst_lerr", 32'(le0), 32'h0);
    clr = 1'b1;
    tick(1);

    // Reset mid-count, no clock edge needed.
    en = 1'b1; ld = 1'b1; d = 16'h0457;
    tick(1);
    chk("t1_load", 32'(q0), 32'h0457);
    ld = 1'b0; ci = 1'b1; up = 1'b1;
    tick(1);
    chk("t1_step", 32'(q0), 32'h0458);
    #1 clr = 1'b0;
    #1;
    chk("t1_async_q", 32'(q0), 32'h0);
    chk("t1_async_zero", 32'(z0), 32'h1);
    chk("t1_async_co", 32'(co0), 32'h0);
    #2 clr = 1'b1;

    // Up wrap.
    ld = 1'b1; d = 16'h9998;
    tick(1);
    ld = 1'b0;
    tick(1);
    chk("t2_q9999", 32'(q0), 32'h9999);
    chk("t2_co0", 32'(co0), 32'h0);
    tick(1);
    chk("t2_wrap_q", 32'(q0), 32'h0000);
    chk("t2_wrap_co", 32'(co0), 32'h1);
    tick(1);
    chk("t2_after_q", 32'(q0), 32'h0001);
    chk("t2_after_co", 32'(co0), 32'h0);
    chk("t2_model", to_bcd(m[0].val, 4), 32'h0001);

    // Down borrow.
    ld = 1'b1; d = 16'h1000; up = 1'b0;
    tick(1);
    ld = 1'b0;
    tick(1);
    chk("t3_borrow_q", 32'(q0), 32'h0999);
    chk("t3_borrow_co", 32'(co0), 32'h0);
    ld = 1'b1; d = 16'h0000;
    tick(1);
    chk("t3_zero", 32'(z0), 32'h1);
    ld = 1'b0;
    tick(1);
    chk("t3_wrap_q", 32'(q0), 32'h9999);
    chk("t3_wrap_co", 32'(co0), 32'h1);
    chk("t3_model", to_bcd(m[0].val, 4), 32'h9999);

    // Invalid load, with CI asserted alongside LOAD.
    ld = 1'b1; ci = 1'b1; d = 16'h3A5F;
    tick(1);
    chk("t4_q", 32'(q0), 32'h3959);
    chk("t4_lerr", 32'(le0), 32'h1);
    chk("t4_co", 32'(co0), 32'h0);
    chk("t4_model", to_bcd(m[0].val, 4), 32'h3959);
    ld = 1'b0; ci = 1'b0;
    tick(1);
    chk("t4_lerr_clr", 32'(le0), 32'h0);
    chk("t4_hold", 32'(q0), 32'h3959);

    // Saturation at the top.
    ld = 1'b1; d = 16'h9999; up = 1'b1; ci = 1'b1;
    tick(1);
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_sat_q", 32'(q1), 32'h9999);
      chk("t5_sat_co", 32'(co1), 32'h1);
    end
    up = 1'b0;
    tick(1);
    chk("t5_down_q", 32'(q1), 32'h9998);
    chk("t5_down_co", 32'(co1), 32'h0);
    chk("t5_wrap_q", 32'(q0), 32'h0001);

    // Gating: ENABLE low, then CI low, with random D/UP.
    for (int i = 0; i < 10; i++) begin
      en = (i >= 5);
      ci = (i < 5) ? 1'($urandom) : 1'b0;
      ld = (i < 5) ? 1'($urandom) : 1'b0;
      d  = 16'($urandom);
      up = 1'($urandom);
      tick(1);
      chk("t6_gate_q0", 32'(q0), 32'h0001);
      chk("t6_gate_q1", 32'(q1), 32'h9998);
      chk("t6_gate_co0", 32'(co0), 32'h0);
      chk("t6_gate_co1", 32'(co1), 32'h0);
    end
    en = 1'b0; ld = 1'b0;

    // Two cascaded 2-digit stages.
    c_en = 1'b1; c_ld = 1'b1; c_d = 8'h00; c_ci = 1'b0;
    tick(1);
    c_ld = 1'b0; c_ci = 1'b1; c_up = 1'b1;
    tick(10000);
    chk("t6_casc_9900", {16'd0, q_hi, q_lo}, 32'h9900);
    chk("t6_casc_lo_co", 32'(co_lo), 32'h1);
    tick(1);
    chk("t6_casc_0001", {16'd0, q_hi, q_lo}, 32'h0001);
    chk("t6_casc_hi_co", 32'(co_hi), 32'h1);
    c_up = 1'b0;
    tick(3);
    chk("t6_casc_9998", {16'd0, q_hi, q_lo}, 32'h9998);
    chk("t6_casc_hi_borrow", 32'(co_hi), 32'h1);
    tick(2);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
